// File: rtl/pipe_mdu_pkg.sv
// Shared encodings for the iterative multiply/divide unit.
package pipe_mdu_pkg;

  // Operation select as presented by the D/E pipeline register.
  typedef enum logic [1:0] {
    MDU_MULU = 2'b00,
    MDU_MUL  = 2'b01,
    MDU_DIVU = 2'b10,
    MDU_DIV  = 2'b11
  } mdu_op_t;

  // Control state of the iteration engine.
  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_RUN  = 2'b01,
    ST_FIX  = 2'b10,
    ST_DONE = 2'b11
  } mdu_state_t;

  // One result bit is produced per iteration.
  localparam int         MDU_ITERS = 32;
  localparam logic [4:0] CNT_LAST  = 5'(MDU_ITERS - 1);

  // Signedness is carried in bit 0 of the encoding, divide in bit 1.
  function automatic logic op_is_signed(input mdu_op_t op);
    return (op == MDU_MUL) || (op == MDU_DIV);
  endfunction

  function automatic logic op_is_div(input mdu_op_t op);
    return (op == MDU_DIVU) || (op == MDU_DIV);
  endfunction

endpackage

// File: rtl/pipe_mdu_neg.sv
// Conditional two's complement: y = neg ? -a : a.
module pipe_mdu_neg #(
  parameter int W = 32
) (
  input  logic [W-1:0] a,
  input  logic         neg,
  output logic [W-1:0] y
);

  assign y = neg ? (~a + W'(1)) : a;

endmodule

// File: rtl/pipe_mdu.sv
// Iterative 32-bit multiply/divide unit for the EXE stage. Runs 32 shift-add
// or restoring-divide iterations while stalling the pipeline, then presents
// the 64-bit result on hi/lo with a single-cycle done.
module pipe_mdu
  import pipe_mdu_pkg::*;
(
  input  logic        clk,
  input  logic        clrn,
  input  logic        estart,
  input  logic [1:0]  eop,
  input  logic [31:0] ea,
  input  logic [31:0] eb,
  input  logic        ecancel,
  output logic        stall,
  output logic        done,
  output logic [31:0] hi,
  output logic [31:0] lo
);

  mdu_state_t state, state_next;
  mdu_op_t    op_in, op_q;

  logic [4:0]  cnt;
  logic        sign_a, sign_b, b_zero;
  logic [31:0] a_raw, a_mag, b_mag;
  logic [31:0] a_mag_in, b_mag_in;
  logic        sign_a_in, sign_b_in;
  logic [63:0] acc, acc_next;

  // Shared adder: multiply adds the multiplicand, divide subtracts the divisor.
  logic [32:0] add_x, add_y;
  logic        add_cin;
  logic [33:0] add_res;

  logic [63:0] prod_fix;
  logic [31:0] quo_fix, rem_fix;
  logic [31:0] res_hi, res_lo;

  assign op_in     = mdu_op_t'(eop);
  // Sign flags only exist for the signed ops; unsigned operands are taken as-is.
  assign sign_a_in = op_is_signed(op_in) & ea[31];
  assign sign_b_in = op_is_signed(op_in) & eb[31];

  pipe_mdu_neg #(.W(32)) u_mag_a (.a(ea), .neg(sign_a_in), .y(a_mag_in));
  pipe_mdu_neg #(.W(32)) u_mag_b (.a(eb), .neg(sign_b_in), .y(b_mag_in));

  // State register.
  always_ff @(posedge clk or posedge clrn) begin
    // NOTE: registers are updated with non-blocking assignments so every
    // flop samples pre-edge values regardless of statement order.
    if (clrn) state <= ST_IDLE;
    else      state <= state_next;
  end

  // Next-state logic; a cancel from a later stage only matters while busy.
  always_comb begin
    // NOTE: every combinational output gets a default first so no path
    // through the block leaves it unassigned and infers a latch.
    state_next = state;
    unique case (state)
      ST_IDLE: if (estart) state_next = ST_RUN;
      ST_RUN: begin
        if (ecancel)              state_next = ST_IDLE;
        else if (cnt == CNT_LAST) state_next = ST_FIX;
      end
      ST_FIX:  state_next = ecancel ? ST_IDLE : ST_DONE;
      ST_DONE: state_next = ST_IDLE;
      default: state_next = ST_IDLE;
    endcase
  end

  // Stall is combinational so the pipeline freezes in the arrival cycle.
  always_comb begin
    stall = 1'b0;
    unique case (state)
      ST_IDLE: stall = estart;
      ST_RUN,
      ST_FIX:  stall = 1'b1;
      default: stall = 1'b0;
    endcase
  end

  // Adder operand select for one iteration.
  always_comb begin
    add_x   = '0;
    add_y   = '0;
    add_cin = 1'b0;
    if (op_is_div(op_q)) begin
      // Partial remainder shifted left by one, minus divisor (x + ~y + 1).
      add_x   = acc[63:31];
      add_y   = ~{1'b0, b_mag};
      add_cin = 1'b1;
    end else begin
      add_x = {1'b0, acc[63:32]};
      add_y = acc[0] ? {1'b0, a_mag} : 33'd0;
    end
  end

  assign add_res = {1'b0, add_x} + {1'b0, add_y} + {33'd0, add_cin};

  // Accumulator step. Multiply keeps the carry as bit 32 of the partial sum
  // and shifts it into the top; divide restores when the trial goes negative.
  // A zero divisor never borrows, which yields all-ones quotient and
  // remainder = dividend for DIVU without any special casing.
  always_comb begin
    acc_next = acc;
    if (op_is_div(op_q)) begin
      acc_next = {(add_res[33] ? add_res[31:0] : acc[62:31]),
                  acc[30:0], add_res[33]};
    end else begin
      acc_next = {add_res[32:0], acc[31:1]};
    end
  end

  // Sign correction of the raw magnitudes. The most-negative / -1 divide
  // falls out naturally: 0x80000000 / 1 negated is again 0x80000000, rem 0.
  pipe_mdu_neg #(.W(64)) u_fix_prod (.a(acc),        .neg(sign_a ^ sign_b), .y(prod_fix));
  pipe_mdu_neg #(.W(32)) u_fix_quo  (.a(acc[31:0]),  .neg(sign_a ^ sign_b), .y(quo_fix));
  pipe_mdu_neg #(.W(32)) u_fix_rem  (.a(acc[63:32]), .neg(sign_a),          .y(rem_fix));

  // Final result select, including the divide-by-zero convention.
  always_comb begin
    res_hi = prod_fix[63:32];
    res_lo = prod_fix[31:0];
    if (op_is_div(op_q)) begin
      if (b_zero) begin
        res_hi = a_raw;
        res_lo = 32'hFFFF_FFFF;
      end else begin
        res_hi = rem_fix;
        res_lo = quo_fix;
      end
    end
  end

  // Operand latch, iteration datapath, result and done registers.
  always_ff @(posedge clk or posedge clrn) begin
    if (clrn) begin
      op_q   <= MDU_MULU;
      sign_a <= 1'b0;
      sign_b <= 1'b0;
      b_zero <= 1'b0;
      a_raw  <= '0;
      a_mag  <= '0;
      b_mag  <= '0;
      acc    <= '0;
      cnt    <= '0;
      hi     <= '0;
      lo     <= '0;
      done   <= 1'b0;
    end else begin
      done <= (state_next == ST_DONE);
      unique case (state)
        ST_IDLE: begin
          if (estart) begin
            op_q   <= op_in;
            sign_a <= sign_a_in;
            sign_b <= sign_b_in;
            b_zero <= (eb == 32'd0);
            a_raw  <= ea;
            a_mag  <= a_mag_in;
            b_mag  <= b_mag_in;
            cnt    <= '0;
            // Multiply starts with the multiplier in the low half; divide
            // starts with the dividend there and an empty remainder.
            acc    <= op_is_div(op_in) ? {32'd0, a_mag_in} : {32'd0, b_mag_in};
          end
        end
        ST_RUN: begin
          acc <= acc_next;
          cnt <= cnt + 5'd1;
        end
        ST_FIX: begin
          if (!ecancel) begin
            hi <= res_hi;
            lo <= res_lo;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_pipe_mdu.sv
// Scoreboard bench for pipe_mdu: directed ops push expected hi/lo; a monitor
// pops and compares whenever done is seen.
module tb_pipe_mdu;

  logic        clk = 1'b0;
  logic        clrn;
  logic        estart;
  logic [1:0]  eop;
  logic [31:0] ea, eb;
  logic        ecancel;
  logic        stall, done;
  logic [31:0] hi, lo;

  int total = 0;
  int bad   = 0;

  logic [63:0] sb_q[$];
  logic [31:0] last_hi, last_lo;

  pipe_mdu dut (
    .clk(clk), .clrn(clrn), .estart(estart), .eop(eop), .ea(ea), .eb(eb),
    .ecancel(ecancel), .stall(stall), .done(done), .hi(hi), .lo(lo)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h, want %0h", name, act, exp);
    end
  endtask

  // Monitor: every done must match the oldest outstanding expectation.
  always @(negedge clk) begin
    if (!clrn && done) begin
      if (sb_q.size() == 0) begin
        check("unexpected_done", 64'd1, 64'd0);
      end else begin
        logic [63:0] exp;
        exp = sb_q.pop_front();
        check("result_hilo", {hi, lo}, exp);
      end
    end
  end

  // Issue one op, hold estart through DONE as a stalled pipeline would, then
  // advance. Operands are scrambled after the accept edge to prove latching.
  task automatic run_op(input string name, input logic [1:0] op,
                        input logic [31:0] a, input logic [31:0] b,
                        input logic [31:0] xhi, input logic [31:0] xlo);
    int edges;
    int stall_low;
    estart = 1'b1; eop = op; ea = a; eb = b;
    #1;
    check({name, "_stall_start"}, 64'(stall), 64'd1);
    sb_q.push_back({xhi, xlo});
    @(posedge clk); #1;
    edges = 0; stall_low = 0;
    ea = ~a; eb = ~b; eop = ~op;
    while (!done && edges < 40) begin
      if (!stall) stall_low++;
      @(posedge clk); #1;
      edges++;
    end
    check({name, "_latency"}, 64'(edges), 64'd33);
    check({name, "_stall_run"}, 64'(stall_low), 64'd0);
    check({name, "_stall_done"}, 64'(stall), 64'd0);
    @(posedge clk); #1;
    check({name, "_done_one_cycle"}, 64'(done), 64'd0);
    estart = 1'b0;
    #1;
    check({name, "_no_restart"}, 64'(stall), 64'd0);
    last_hi = xhi; last_lo = xlo;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int done_seen;
    clrn = 1'b1; estart = 1'b0; eop = 2'b00; ea = '0; eb = '0; ecancel = 1'b0;
    last_hi = '0; last_lo = '0;
    #2;
    check("reset_hi", 64'(hi), 64'd0);
    check("reset_lo", 64'(lo), 64'd0);
    check("reset_done", 64'(done), 64'd0);
    check("reset_stall_idle", 64'(stall), 64'd0);
    estart = 1'b1; #1;
    check("reset_stall_follows_estart", 64'(stall), 64'd1);
    estart = 1'b0;
    @(posedge clk); #1;
    clrn = 1'b0;
    @(posedge clk); #1;

    // Back-to-back pair: second op is issued in the cycle right after DONE.
    run_op("mulu_max", 2'b00, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001);
    run_op("mulu_3x4", 2'b00, 32'd3, 32'd4, 32'd0, 32'd12);
    run_op("mul_neg3x7", 2'b01, 32'hFFFF_FFFD, 32'd7, 32'hFFFF_FFFF, 32'hFFFF_FFEB);
    run_op("mul_minsq", 2'b01, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 32'h0000_0000);
    run_op("div_neg7_2", 2'b11, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFD);
    run_op("div_7_neg2", 2'b11, 32'd7, 32'hFFFF_FFFE, 32'h0000_0001, 32'hFFFF_FFFD);
    run_op("divu_100_7", 2'b10, 32'd100, 32'd7, 32'd2, 32'd14);
    run_op("divu_5_0", 2'b10, 32'd5, 32'd0, 32'd5, 32'hFFFF_FFFF);
    run_op("div_ovf", 2'b11, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 32'h8000_0000);
    run_op("div_neg7_0", 2'b11, 32'hFFFF_FFF9, 32'd0, 32'hFFFF_FFF9, 32'hFFFF_FFFF);

    // Cancel at iteration 10: back to IDLE, prior result retained, no done.
    estart = 1'b1; eop = 2'b10; ea = 32'd1000; eb = 32'd3;
    @(posedge clk); #1;
    repeat (10) begin @(posedge clk); #1; end
    ecancel = 1'b1; estart = 1'b0;
    @(posedge clk); #1;
    ecancel = 1'b0;
    check("cancel_stall", 64'(stall), 64'd0);
    check("cancel_hold", {32'(hi), 32'(lo)}, {last_hi, last_lo});
    done_seen = 0;
    repeat (40) begin
      if (done) done_seen++;
      @(posedge clk); #1;
    end
    check("cancel_no_done", 64'(done_seen), 64'd0);

    // Asynchronous reset in the middle of a run.
    estart = 1'b1; eop = 2'b01; ea = 32'd12345; eb = 32'd678;
    @(posedge clk); #1;
    repeat (5) begin @(posedge clk); #1; end
    estart = 1'b0;
    #2 clrn = 1'b1;
    #1;
    check("midrun_reset_hi", 64'(hi), 64'd0);
    check("midrun_reset_lo", 64'(lo), 64'd0);
    check("midrun_reset_done", 64'(done), 64'd0);
    check("midrun_reset_stall", 64'(stall), 64'd0);
    @(posedge clk); #1;
    clrn = 1'b0;
    done_seen = 0;
    repeat (40) begin
      if (done) done_seen++;
      @(posedge clk); #1;
    end
    check("reset_no_done", 64'(done_seen), 64'd0);

    run_op("mulu_after_reset", 2'b00, 32'd3, 32'd4, 32'd0, 32'd12);

    repeat (3) @(posedge clk);
    #1;
    check("scoreboard_drained", 64'(sb_q.size()), 64'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
